comparator_arbiter: RTL and testbench

// Shares a single 8-bit magnitude comparator (a<b, a>b, a==b) between NUM_REQ

---
 rtl/comparator_arbiter_if.sv | 29 ++
 rtl/comparator_arbiter.sv | 101 ++++++++++
 tb/tb_comparator_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/comparator_arbiter_if.sv
// Request/response bundle between the client blocks and the shared comparator arbiter.
// The master side issues requests and consumes results; the slave side is the arbiter.
interface comparator_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic                     resp_lt;
  logic                     resp_gt;
  logic                     resp_eq;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_lt, resp_gt, resp_eq
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_lt, resp_gt, resp_eq
  );
endinterface

// File: rtl/comparator_arbiter.sv
// Round-robin arbiter sharing one unsigned magnitude comparator among NUM_REQ requesters.
// A request is accepted in IDLE, compared in CMP and held in RESP until the consumer takes it.
module comparator_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  comparator_arbiter_if.slave bus,
  output logic                busy_o
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, CMP, RESP} state_t;

  state_t           state_q;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  id_q;
  logic [WIDTH-1:0] opA_q;
  logic [WIDTH-1:0] opB_q;
  logic             respValid_q;
  logic             lt_q;
  logic             gt_q;
  logic             eq_q;

  logic             found_d;
  logic [ID_W-1:0]  grant_d;
  logic [ID_W:0]    slot;

  // Search from ptr upward, wrapping, and take the first valid requester.
  always_comb begin
    found_d = 1'b0;
    grant_d = '0;
    slot    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (slot >= (ID_W+1)'(NUM_REQ)) begin
        slot = slot - (ID_W+1)'(NUM_REQ);
      end
      if (!found_d && bus.req_valid[slot[ID_W-1:0]]) begin
        found_d = 1'b1;
        grant_d = slot[ID_W-1:0];
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (reset_n_i && (state_q == IDLE) && found_d) begin
      bus.req_ready[grant_d] = 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      opA_q       <= '0;
      opB_q       <= '0;
      respValid_q <= 1'b0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            id_q    <= grant_d;
            opA_q   <= bus.req_a[int'(grant_d)*WIDTH +: WIDTH];
            opB_q   <= bus.req_b[int'(grant_d)*WIDTH +: WIDTH];
            state_q <= CMP;
          end
        end
        CMP: begin
          lt_q        <= (opA_q < opB_q);
          gt_q        <= (opA_q > opB_q);
          eq_q        <= (opA_q == opB_q);
          respValid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          // The winner moves to the back of the queue once its result is taken.
          if (bus.resp_ready) begin
            respValid_q <= 1'b0;
            ptr_q       <= (id_q == ID_W'(NUM_REQ-1)) ? '0 : id_q + 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.resp_valid = respValid_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_lt    = lt_q;
  assign bus.resp_gt    = gt_q;
  assign bus.resp_eq    = eq_q;
  assign busy_o         = (state_q != IDLE);
endmodule

// File: tb/tb_comparator_arbiter.sv
// Self-checking bench for comparator_arbiter: directed table vectors, hand-written
// backpressure and reset sequences, and a random run checked against a cycle model.
module tb_comparator_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clock  = 1'b0;
  logic resetN = 1'b0;
  logic busy;
  int   checksDone   = 0;
  int   checksPassed = 0;

  comparator_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  comparator_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clock_i   (clock),
    .reset_n_i (resetN),
    .bus       (bus.slave),
    .busy_o    (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit             doReset;
    logic [N-1:0]   valid;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    int             expId;
    logic [2:0]     expFlags;
  } vec_t;

  vec_t           vecs[9];
  int             waited;
  logic [N-1:0]   ready;
  bit             pending[N];
  logic [W-1:0]   opA[N];
  logic [W-1:0]   opB[N];
  logic [N-1:0]   rv;
  logic [N*W-1:0] ra;
  logic [N*W-1:0] rb;
  logic [N-1:0]   expReady;
  int             mState, mPtr, mId, g;
  logic [W-1:0]   mA, mB;
  bit             found;
  int             accepts, dutResps;

  function automatic logic [31:0] pack4(input logic [7:0] v3, input logic [7:0] v2,
                                        input logic [7:0] v1, input logic [7:0] v0);
    return {v3, v2, v1, v0};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checksDone++;
    if (actual === expected) begin
      checksPassed++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N*W-1:0] a,
                               input logic [N*W-1:0] b, input logic respReady);
    bus.req_valid  = valid;
    bus.req_a      = a;
    bus.req_b      = b;
    bus.resp_ready = respReady;
  endtask

  task automatic waitAccept(input int maxCycles, output int cycles, output logic [N-1:0] rdy);
    cycles = 0;
    @(negedge clock);
    while (bus.req_ready == '0 && cycles < maxCycles) begin
      @(negedge clock);
      cycles++;
    end
    rdy = bus.req_ready;
  endtask

  task automatic resetDut();
    resetN = 1'b0;
    applyStimulus('1, '0, '0, 1'b0);
    @(posedge clock);
    @(negedge clock);
    checkOutput("reset resp_valid", bus.resp_valid, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset resp_id", bus.resp_id, 0);
    checkOutput("reset flags", {bus.resp_lt, bus.resp_gt, bus.resp_eq}, 0);
    checkOutput("reset req_ready", bus.req_ready, 0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    applyStimulus('0, '0, '0, 1'b0);
  endtask

  initial begin
    $display("[TB] start");
    applyStimulus('0, '0, '0, 1'b0);
    vecs[0] = '{1'b1, 4'b0001, pack4(8'h00, 8'h00, 8'h00, 8'h10), pack4(8'h00, 8'h00, 8'h00, 8'h20), 0, 3'b100};
    vecs[1] = '{1'b1, 4'b1111, pack4(8'h80, 8'h00, 8'hFF, 8'h05), pack4(8'h80, 8'hFF, 8'h00, 8'h05), 0, 3'b001};
    vecs[2] = '{1'b0, 4'b1111, pack4(8'h80, 8'h00, 8'hFF, 8'h05), pack4(8'h80, 8'hFF, 8'h00, 8'h05), 1, 3'b010};
    vecs[3] = '{1'b0, 4'b1111, pack4(8'h80, 8'h00, 8'hFF, 8'h05), pack4(8'h80, 8'hFF, 8'h00, 8'h05), 2, 3'b100};
    vecs[4] = '{1'b0, 4'b1111, pack4(8'h80, 8'h00, 8'hFF, 8'h05), pack4(8'h80, 8'hFF, 8'h00, 8'h05), 3, 3'b001};
    vecs[5] = '{1'b0, 4'b1111, pack4(8'h80, 8'h00, 8'hFF, 8'h05), pack4(8'h80, 8'hFF, 8'h00, 8'h05), 0, 3'b001};
    vecs[6] = '{1'b0, 4'b1000, pack4(8'h30, 8'h00, 8'h00, 8'h7F), pack4(8'h31, 8'h00, 8'h00, 8'h7E), 3, 3'b100};
    vecs[7] = '{1'b0, 4'b1001, pack4(8'h30, 8'h00, 8'h00, 8'h7F), pack4(8'h31, 8'h00, 8'h00, 8'h7E), 0, 3'b010};
    vecs[8] = '{1'b0, 4'b1001, pack4(8'h30, 8'h00, 8'h00, 8'h7F), pack4(8'h31, 8'h00, 8'h00, 8'h7E), 3, 3'b100};

    for (int i = 0; i < 9; i++) begin
      if (vecs[i].doReset) resetDut();
      applyStimulus(vecs[i].valid, vecs[i].a, vecs[i].b, 1'b1);
      waitAccept(20, waited, ready);
      checkOutput($sformatf("v%0d same-cycle ready", i), waited, 0);
      checkOutput($sformatf("v%0d grant", i), ready, 32'(1) << vecs[i].expId);
      checkOutput($sformatf("v%0d idle busy", i), busy, 0);
      @(posedge clock);
      #1;
      bus.req_valid = vecs[i].valid & ~ready;
      @(negedge clock);
      checkOutput($sformatf("v%0d cmp resp_valid", i), bus.resp_valid, 0);
      checkOutput($sformatf("v%0d cmp busy", i), busy, 1);
      checkOutput($sformatf("v%0d cmp req_ready", i), bus.req_ready, 0);
      @(negedge clock);
      checkOutput($sformatf("v%0d resp_valid", i), bus.resp_valid, 1);
      checkOutput($sformatf("v%0d resp_id", i), bus.resp_id, vecs[i].expId);
      checkOutput($sformatf("v%0d flags", i), {bus.resp_lt, bus.resp_gt, bus.resp_eq}, vecs[i].expFlags);
      checkOutput($sformatf("v%0d resp req_ready", i), bus.req_ready, 0);
      @(posedge clock);
      #1;
    end

    // Backpressure: result held for five cycles with other requesters waiting.
    applyStimulus(4'b0100, pack4(8'h00, 8'h44, 8'h00, 8'h00), pack4(8'h00, 8'h43, 8'h00, 8'h00), 1'b0);
    waitAccept(20, waited, ready);
    checkOutput("hold grant", ready, 4'b0100);
    @(posedge clock);
    #1;
    bus.req_valid = 4'b1011;
    @(posedge clock);
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checkOutput($sformatf("hold%0d resp_valid", k), bus.resp_valid, 1);
      checkOutput($sformatf("hold%0d resp_id", k), bus.resp_id, 2);
      checkOutput($sformatf("hold%0d flags", k), {bus.resp_lt, bus.resp_gt, bus.resp_eq}, 3'b010);
      checkOutput($sformatf("hold%0d req_ready", k), bus.req_ready, 0);
      checkOutput($sformatf("hold%0d busy", k), busy, 1);
      @(posedge clock);
    end
    #1;
    bus.resp_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checkOutput("release busy", busy, 0);
    checkOutput("release resp_valid", bus.resp_valid, 0);
    checkOutput("release next grant", bus.req_ready, 4'b1000);
    bus.req_valid = '0;

    // Reset while requester 2 is being compared.
    @(posedge clock);
    #1;
    applyStimulus(4'b0100, pack4(8'h00, 8'h10, 8'h00, 8'h00), pack4(8'h00, 8'h90, 8'h00, 8'h00), 1'b1);
    waitAccept(20, waited, ready);
    checkOutput("midreset grant", ready, 4'b0100);
    @(posedge clock);
    #1;
    resetN = 1'b0;
    bus.req_valid = 4'b1111;
    @(posedge clock);
    @(negedge clock);
    checkOutput("midreset resp_valid", bus.resp_valid, 0);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset req_ready", bus.req_ready, 0);
    checkOutput("midreset resp_id", bus.resp_id, 0);
    checkOutput("midreset flags", {bus.resp_lt, bus.resp_gt, bus.resp_eq}, 0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
    bus.req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checkOutput($sformatf("postreset%0d resp_valid", k), bus.resp_valid, 0);
    end
    @(posedge clock);
    #1;
    bus.req_valid = 4'b0101;
    @(negedge clock);
    checkOutput("postreset ptr", bus.req_ready, 4'b0001);
    bus.req_valid = 4'b0100;
    #1;
    checkOutput("postreset grant", bus.req_ready, 4'b0100);
    @(posedge clock);
    #1;
    bus.req_valid = '0;
    @(negedge clock);
    checkOutput("postreset cmp resp_valid", bus.resp_valid, 0);
    @(negedge clock);
    checkOutput("postreset resp_valid", bus.resp_valid, 1);
    checkOutput("postreset resp_id", bus.resp_id, 2);
    checkOutput("postreset flags", {bus.resp_lt, bus.resp_gt, bus.resp_eq}, 3'b100);
    @(posedge clock);
    #1;

    // Random traffic with backpressure against a cycle-level model.
    resetDut();
    mState = 0; mPtr = 0; mId = 0; mA = '0; mB = '0;
    accepts = 0; dutResps = 0;
    for (int r = 0; r < N; r++) begin
      pending[r] = 1'b0; opA[r] = '0; opB[r] = '0;
    end
    for (int cyc = 0; cyc < 60000 && (accepts < 2000 || mState != 0); cyc++) begin
      for (int r = 0; r < N; r++) begin
        if (accepts >= 2000) begin
          pending[r] = 1'b0;
        end else if (!pending[r] && $urandom_range(2) == 0) begin
          pending[r] = 1'b1;
          opA[r] = 8'($urandom);
          opB[r] = ($urandom_range(3) == 0) ? opA[r] : 8'($urandom);
        end else if (pending[r] && $urandom_range(15) == 0) begin
          pending[r] = 1'b0;
        end
        rv[r] = pending[r];
        ra[r*W +: W] = opA[r];
        rb[r*W +: W] = opB[r];
      end
      applyStimulus(rv, ra, rb, $urandom_range(1) == 1);
      @(negedge clock);
      expReady = '0;
      found = 1'b0;
      g = 0;
      if (mState == 0) begin
        for (int k = 0; k < N; k++) begin
          if (!found && rv[(mPtr + k) % N]) begin
            found = 1'b1;
            g = (mPtr + k) % N;
          end
        end
        if (found) expReady[g] = 1'b1;
      end
      checkOutput("rand req_ready", bus.req_ready, expReady);
      checkOutput("rand resp_valid", bus.resp_valid, (mState == 2) ? 1 : 0);
      checkOutput("rand busy", busy, (mState != 0) ? 1 : 0);
      if (mState == 2) begin
        checkOutput("rand resp_id", bus.resp_id, mId);
        checkOutput("rand flags", {bus.resp_lt, bus.resp_gt, bus.resp_eq}, {mA < mB, mA > mB, mA == mB});
      end
      if (bus.resp_valid && bus.resp_ready) dutResps++;
      @(posedge clock);
      if (mState == 0 && found) begin
        mId = g; mA = opA[g]; mB = opB[g];
        pending[g] = 1'b0;
        accepts++;
        mState = 1;
      end else if (mState == 1) begin
        mState = 2;
      end else if (mState == 2 && bus.resp_ready) begin
        mPtr = (mId + 1) % N;
        mState = 0;
      end
      #1;
    end
    checkOutput("rand accepts", accepts, 2000);
    checkOutput("rand responses", dutResps, accepts);

    $display("%0d/%0d checks passed", checksPassed, checksDone);
    $finish;
  end
endmodule
